// File: rtl/oram_pkg.sv
// Shared definitions for the output-RAM port arbiter: RAM geometry and the
// requester IDs that also serve as the round-robin pointer encoding.
package oram_pkg;

   localparam int ORAM_ADDR_W = 13;
   localparam int ORAM_DATA_W = 64;

   typedef enum logic [1:0] {
      REQ_PPU = 2'd0,
      REQ_SF  = 2'd1,
      REQ_RD  = 2'd2
   } req_e;

   function automatic req_e req_next(input req_e r);
      case (r)
         REQ_PPU: return REQ_SF;
         REQ_SF:  return REQ_RD;
         default: return REQ_PPU;
      endcase
   endfunction

endpackage

// File: rtl/oram_port_arbiter_sync_fifo.sv
// Small synchronous FIFO with a per-entry key/valid view so the arbiter can
// compare a read address against every queued write.
module sync_fifo #(
   parameter int WIDTH = 77,
   parameter int DEPTH = 4,
   parameter int KEY_W = 13
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [WIDTH-1:0]           o_head,
   output logic [DEPTH*KEY_W-1:0]     o_keys,
   output logic [DEPTH-1:0]           o_vld
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;
   logic [PTR_W-1:0] off;

   assign o_empty = (count_q == '0);
   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_count = count_q;
   assign o_head  = mem_q[rd_ptr_q];

   always_comb begin
      // A pop on a full FIFO frees the slot the simultaneous push lands in.
      do_pop   = i_pop && !o_empty;
      do_push  = i_push && (!o_full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_comb begin
      o_keys = '0;
      o_vld  = '0;
      off    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off                      = PTR_W'(i) - rd_ptr_q;
         o_vld[i]                 = ({1'b0, off} < count_q);
         o_keys[i*KEY_W +: KEY_W] = mem_q[i][WIDTH-1 -: KEY_W];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; the count and pointers alone define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_data;
   end

endmodule

// File: rtl/oram_port_arbiter.sv
// Shares the single-port output RAM between two buffered write sources (PPU, SF)
// and a host read port; one access per cycle, urgent-then-round-robin arbitration.
module oram_port_arbiter
   import oram_pkg::*;
#(
   parameter int ADDR_W     = ORAM_ADDR_W,
   parameter int DATA_W     = ORAM_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ppu_we,
   input  logic [ADDR_W-1:0] i_ppu_addr,
   input  logic [DATA_W-1:0] i_ppu_data,
   input  logic              i_sf_we,
   input  logic [ADDR_W-1:0] i_sf_addr,
   input  logic [DATA_W-1:0] i_sf_data,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_gnt,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_data,
   input  logic [DATA_W-1:0] i_ram_q,
   output logic              o_busy,
   output logic [1:0]        o_ovf
);

   localparam int ENT_W = ADDR_W + DATA_W;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                         ppu_full, ppu_empty, sf_full, sf_empty;
   logic [CNT_W-1:0]             ppu_count, sf_count;
   logic [ENT_W-1:0]             ppu_head, sf_head;
   logic [FIFO_DEPTH*ADDR_W-1:0] ppu_keys, sf_keys;
   logic [FIFO_DEPTH-1:0]        ppu_vld, sf_vld;
   logic                         ppu_pop, sf_pop;

   logic       hazard, grant;
   logic [2:0] cand;
   req_e       win;
   int         idx;

   req_e              rr_q, rr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_vld_q, rd_vld_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [1:0]        ovf_q, ovf_d;

   sync_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH), .KEY_W(ADDR_W)) u_ppu_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_ppu_we),
      .i_pop   (ppu_pop),
      .i_data  ({i_ppu_addr, i_ppu_data}),
      .o_full  (ppu_full),
      .o_empty (ppu_empty),
      .o_count (ppu_count),
      .o_head  (ppu_head),
      .o_keys  (ppu_keys),
      .o_vld   (ppu_vld)
   );

   sync_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH), .KEY_W(ADDR_W)) u_sf_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_sf_we),
      .i_pop   (sf_pop),
      .i_data  ({i_sf_addr, i_sf_data}),
      .o_full  (sf_full),
      .o_empty (sf_empty),
      .o_count (sf_count),
      .o_head  (sf_head),
      .o_keys  (sf_keys),
      .o_vld   (sf_vld)
   );

   always_comb begin
      hazard = (i_ppu_we && (i_ppu_addr == i_rd_addr)) ||
               (i_sf_we  && (i_sf_addr  == i_rd_addr));
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (ppu_vld[i] && (ppu_keys[i*ADDR_W +: ADDR_W] == i_rd_addr)) hazard = 1'b1;
         if (sf_vld[i]  && (sf_keys[i*ADDR_W +: ADDR_W]  == i_rd_addr)) hazard = 1'b1;
      end
   end

   // NOTE: every signal below gets a default first so no path leaves a latch behind.
   always_comb begin
      cand  = {i_rd_req && !hazard, !sf_empty, !ppu_empty};
      grant = 1'b0;
      win   = REQ_PPU;
      idx   = 0;
      if (!i_rst) begin
         if (ppu_count >= CNT_W'(FIFO_DEPTH - 1)) begin
            grant = 1'b1;
            win   = REQ_PPU;
         end else if (sf_count >= CNT_W'(FIFO_DEPTH - 1)) begin
            grant = 1'b1;
            win   = REQ_SF;
         end else begin
            for (int k = 0; k < 3; k++) begin
               idx = (int'(rr_q) + k) % 3;
               if (!grant && cand[idx]) begin
                  grant = 1'b1;
                  win   = req_e'(idx[1:0]);
               end
            end
         end
      end

      ppu_pop    = grant && (win == REQ_PPU);
      sf_pop     = grant && (win == REQ_SF);
      o_rd_gnt   = grant && (win == REQ_RD);
      o_ram_we   = ppu_pop || sf_pop;
      o_ram_addr = addr_q;
      o_ram_data = '0;
      if (ppu_pop)       {o_ram_addr, o_ram_data} = ppu_head;
      else if (sf_pop)   {o_ram_addr, o_ram_data} = sf_head;
      else if (o_rd_gnt) o_ram_addr = i_rd_addr;

      addr_d   = o_ram_addr;
      rr_d     = grant ? req_next(win) : rr_q;
      rd_vld_d = o_rd_gnt;
      // i_ram_q is already registered by the RAM; pass it through while valid and hold it after.
      rd_data_d = rd_vld_q ? i_ram_q : rd_data_q;
      ovf_d     = ovf_q | {i_sf_we && sf_full && !sf_pop, i_ppu_we && ppu_full && !ppu_pop};
   end

   assign o_rd_valid = rd_vld_q;
   assign o_rd_data  = rd_data_d;
   assign o_busy     = !ppu_empty || !sf_empty;
   assign o_ovf      = ovf_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_q      <= REQ_PPU;
         addr_q    <= '0;
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
         ovf_q     <= '0;
      end else begin
         rr_q      <= rr_d;
         addr_q    <= addr_d;
         rd_vld_q  <= rd_vld_d;
         rd_data_q <= rd_data_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule
